// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - segment pattern constants and scan FSM state type
package seg_pkg;

    // Active-low {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] BCD_BLANK = 4'hF;

    typedef enum logic [1:0] {
        IDLE,
        TRACK,
        HELD
    } state_t;

endpackage

// File: rtl/seg_scan_decoder_if.sv
// rtl/seg_scan_decoder_if.sv - scanned display bus and decoded result signals
interface seg_scan_decoder_if #(
    parameter int NDIG = 4
);
    logic [6:0]        HEX_IN;
    logic [NDIG-1:0]   DIG_EN;
    logic              ERR_CLR;
    logic [4*NDIG-1:0] DIGITS;
    logic [NDIG-1:0]   VALID;
    logic              UPDATE;
    logic [2:0]        UPD_IDX;
    logic              ERR;

    modport master (
        output HEX_IN, DIG_EN, ERR_CLR,
        input  DIGITS, VALID, UPDATE, UPD_IDX, ERR
    );

    modport slave (
        input  HEX_IN, DIG_EN, ERR_CLR,
        output DIGITS, VALID, UPDATE, UPD_IDX, ERR
    );
endinterface

// File: rtl/seg_to_bcd.sv
// rtl/seg_to_bcd.sv - combinational 7-segment pattern to BCD classifier
module seg_to_bcd
    import seg_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] bcd,
    output logic       is_digit,
    output logic       is_blank
);

    always_comb begin
        bcd      = BCD_BLANK;
        is_digit = 1'b1;
        is_blank = 1'b0;
        case (pattern)
            SEG_0:     bcd = 4'd0;
            SEG_1:     bcd = 4'd1;
            SEG_2:     bcd = 4'd2;
            SEG_3:     bcd = 4'd3;
            SEG_4:     bcd = 4'd4;
            SEG_5:     bcd = 4'd5;
            SEG_6:     bcd = 4'd6;
            SEG_7:     bcd = 4'd7;
            SEG_8:     bcd = 4'd8;
            SEG_9:     bcd = 4'd9;
            SEG_BLANK: begin
                is_digit = 1'b0;
                is_blank = 1'b1;
            end
            default:   is_digit = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// rtl/seg_scan_decoder.sv - debounced decode of a multiplexed active-low 7-segment bus
module seg_scan_decoder
    import seg_pkg::*;
#(
    parameter int NDIG          = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                CLOCK_50,
    input  logic                RESET,
    seg_scan_decoder_if.slave   bus
);

    localparam logic [7:0] STABLE_M1 = 8'(STABLE_CYCLES - 1);

    state_t            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [NDIG-1:0]   held_en;
    logic [6:0]        held_hex;
    logic              commit;
    logic              same;
    logic              one_hot;
    logic [3:0]        n_set;
    logic [2:0]        idx;

    logic [3:0]        bcd;
    logic              is_digit;
    logic              is_blank;

    logic [4*NDIG-1:0] digits_q, digits_d;
    logic [NDIG-1:0]   valid_q, valid_d;
    logic              update_q;
    logic [2:0]        upd_idx_q;
    logic              err_q;

    seg_to_bcd u_dec (
        .pattern  (bus.HEX_IN),
        .bcd      (bcd),
        .is_digit (is_digit),
        .is_blank (is_blank)
    );

    assign same = (bus.DIG_EN == held_en) && (bus.HEX_IN == held_hex);

    always_comb begin
        n_set = 4'd0;
        idx   = 3'd0;
        for (int i = 0; i < NDIG; i++) begin
            if (bus.DIG_EN[i]) begin
                n_set = n_set + 4'd1;
                idx   = 3'(i);
            end
        end
    end

    assign one_hot = (n_set == 4'd1);

    // The count includes the current sample, so a fresh pattern starts at 1
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = 8'd0;
                if (one_hot) begin
                    state_d = TRACK;
                    cnt_d   = 8'd1;
                end
            end
            TRACK: begin
                if (!one_hot) begin
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                end else if (!same) begin
                    cnt_d = 8'd1;
                end else if (cnt_q == STABLE_M1) begin
                    commit  = 1'b1;
                    state_d = HELD;
                    cnt_d   = cnt_q + 8'd1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            HELD: begin
                if (!same) begin
                    if (!one_hot) begin
                        state_d = IDLE;
                        cnt_d   = 8'd0;
                    end else begin
                        state_d = TRACK;
                        cnt_d   = 8'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    always_comb begin
        digits_d = digits_q;
        valid_d  = valid_q;
        for (int i = 0; i < NDIG; i++) begin
            if (bus.DIG_EN[i]) begin
                digits_d[4*i +: 4] = bcd;
                valid_d[i]         = is_digit;
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state_q   <= IDLE;
            cnt_q     <= 8'd0;
            held_en   <= '0;
            held_hex  <= '0;
            digits_q  <= {NDIG{BCD_BLANK}};
            valid_q   <= '0;
            update_q  <= 1'b0;
            upd_idx_q <= 3'd0;
            err_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            held_en  <= bus.DIG_EN;
            held_hex <= bus.HEX_IN;
            update_q <= commit;
            if (commit) begin
                digits_q  <= digits_d;
                valid_q   <= valid_d;
                upd_idx_q <= idx;
            end
            // A fresh error outranks a simultaneous clear
            if (commit && !is_digit && !is_blank) begin
                err_q <= 1'b1;
            end else if (bus.ERR_CLR) begin
                err_q <= 1'b0;
            end
        end
    end

    assign bus.DIGITS  = digits_q;
    assign bus.VALID   = valid_q;
    assign bus.UPDATE  = update_q;
    assign bus.UPD_IDX = upd_idx_q;
    assign bus.ERR     = err_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb/tb_seg_scan_decoder.sv - self-checking bench for seg_scan_decoder
module tb_seg_scan_decoder;

    localparam int NDIG   = 4;
    localparam int STABLE = 4;

    typedef struct {
        logic [3:0] en;
        logic [6:0] hex;
        int         n;
        logic [3:0] bcd;
        logic       vld;
    } vec_t;

    typedef struct {
        logic [2:0] idx;
        logic [3:0] bcd;
        logic       vld;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    vec_t        vecs[$];
    exp_t        sb[$];
    logic [15:0] exp_digits = 16'hFFFF;
    logic [3:0]  exp_valid  = 4'b0000;

    seg_scan_decoder_if #(.NDIG(NDIG)) bus ();

    seg_scan_decoder #(.NDIG(NDIG), .STABLE_CYCLES(STABLE)) dut (
        .CLOCK_50 (clk),
        .RESET    (rst),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [3:0] en, input logic [3:0] bcd, input logic vld);
        exp_t e;
        for (int i = 0; i < NDIG; i++) begin
            if (en[i]) begin
                e.idx = 3'(i);
                exp_digits[4*i +: 4] = bcd;
                exp_valid[i] = vld;
            end
        end
        e.bcd = bcd;
        e.vld = vld;
        sb.push_back(e);
    endtask

    task automatic dwell(input vec_t v);
        logic hit;
        bus.DIG_EN = v.en;
        bus.HEX_IN = v.hex;
        hit = (v.n >= STABLE) && $onehot(v.en);
        if (hit) push_exp(v.en, v.bcd, v.vld);
        for (int k = 1; k <= v.n; k++) begin
            tick();
            check("update_pulse", 32'(bus.UPDATE), 32'(hit && (k == STABLE)));
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.UPDATE) begin
            check("update_expected", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("upd_idx", 32'(bus.UPD_IDX), 32'(e.idx));
                check("digit_slice", 32'(bus.DIGITS[4*e.idx +: 4]), 32'(e.bcd));
                check("valid_bit", 32'(bus.VALID[e.idx]), 32'(e.vld));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.DIG_EN  = '0;
        bus.HEX_IN  = '0;
        bus.ERR_CLR = 1'b0;

        vecs.push_back('{4'b0010, 7'b0110000, 14, 4'd3, 1'b1});
        vecs.push_back('{4'b0001, 7'b1111001,  6, 4'd1, 1'b1});
        vecs.push_back('{4'b0010, 7'b0010000,  6, 4'd9, 1'b1});
        vecs.push_back('{4'b0100, 7'b1111111,  6, 4'hF, 1'b0});
        vecs.push_back('{4'b1000, 7'b1111000,  6, 4'd7, 1'b1});
        vecs.push_back('{4'b0001, 7'b1000000,  4, 4'd0, 1'b1});
        vecs.push_back('{4'b0010, 7'b0100100,  4, 4'd2, 1'b1});
        vecs.push_back('{4'b0100, 7'b0011001,  4, 4'd4, 1'b1});
        vecs.push_back('{4'b1000, 7'b0000010,  4, 4'd6, 1'b1});
        vecs.push_back('{4'b0001, 7'b0010010,  3, 4'd5, 1'b1});
        vecs.push_back('{4'b0001, 7'b0000000,  4, 4'd8, 1'b1});
        vecs.push_back('{4'b0110, 7'b1111001, 10, 4'd1, 1'b1});
        vecs.push_back('{4'b0001, 7'b0000000,  4, 4'd8, 1'b1});
        vecs.push_back('{4'b0010, 7'b0010010,  5, 4'd5, 1'b1});

        repeat (2) tick();
        check("rst_digits", 32'(bus.DIGITS), 32'h0000FFFF);
        check("rst_valid", 32'(bus.VALID), 32'h0);
        check("rst_err", 32'(bus.ERR), 32'h0);
        check("rst_update", 32'(bus.UPDATE), 32'h0);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            dwell(vecs[i]);
            check("digits_model", 32'(bus.DIGITS), 32'(exp_digits));
            check("valid_model", 32'(bus.VALID), 32'(exp_valid));
            if (i == 4) begin
                check("scan_digits", 32'(bus.DIGITS), 32'h00007F91);
                check("scan_valid", 32'(bus.VALID), 32'hB);
            end
        end
        check("no_err_yet", 32'(bus.ERR), 32'h0);

        dwell('{4'b0001, 7'b1111110, 4, 4'hF, 1'b0});
        check("err_set", 32'(bus.ERR), 32'h1);
        check("err_valid0", 32'(bus.VALID[0]), 32'h0);
        bus.ERR_CLR = 1'b1;
        tick();
        bus.ERR_CLR = 1'b0;
        check("err_cleared", 32'(bus.ERR), 32'h0);

        bus.DIG_EN = 4'b0010;
        bus.HEX_IN = 7'b0000001;
        push_exp(4'b0010, 4'hF, 1'b0);
        repeat (3) tick();
        bus.ERR_CLR = 1'b1;
        tick();
        bus.ERR_CLR = 1'b0;
        check("err_set_wins_upd", 32'(bus.UPDATE), 32'h1);
        check("err_set_wins", 32'(bus.ERR), 32'h1);
        check("err_digits", 32'(bus.DIGITS), 32'(exp_digits));

        bus.DIG_EN = 4'b0100;
        bus.HEX_IN = 7'b1000000;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("pre_rst_update", 32'(bus.UPDATE), 32'h0);
        end
        rst = 1'b1;
        tick();
        check("rst_commit_update", 32'(bus.UPDATE), 32'h0);
        check("rst_commit_digits", 32'(bus.DIGITS), 32'h0000FFFF);
        check("rst_commit_valid", 32'(bus.VALID), 32'h0);
        check("rst_commit_err", 32'(bus.ERR), 32'h0);
        check("rst_commit_idx", 32'(bus.UPD_IDX), 32'h0);
        bus.DIG_EN = '0;
        rst = 1'b0;
        repeat (3) tick();
        check("post_rst_update", 32'(bus.UPDATE), 32'h0);
        check("scoreboard_drained", 32'(sb.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
